// File: rtl/regs_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Covers the grant encodings, the default widths and the secondary-source selector.
package regs_wb_arbiter_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_EX   = 2'd1;
  localparam logic [1:0] GNT_LSU  = 2'd2;
  localparam logic [1:0] GNT_DIV  = 2'd3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    SEL_LSU = 1'b0,
    SEL_DIV = 1'b1
  } sec_sel_e;

endpackage

// File: rtl/regs_wb_arbiter_if.sv
// Writeback bus between the EX/LSU/DIV sources and the arbiter.
// The same bus also carries the register-file write port.
interface regs_wb_arbiter_if
  import regs_wb_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          ex_wen_i;
  logic [AW-1:0] ex_waddr_i;
  logic [DW-1:0] ex_wdata_i;
  logic          lsu_valid_i;
  logic [AW-1:0] lsu_waddr_i;
  logic [DW-1:0] lsu_wdata_i;
  logic          lsu_ready_o;
  logic          div_valid_i;
  logic [AW-1:0] div_waddr_i;
  logic [DW-1:0] div_wdata_i;
  logic          div_ready_o;
  logic          stall_o;
  logic          reg_wen_o;
  logic [AW-1:0] reg_waddr_o;
  logic [DW-1:0] reg_wdata_o;
  logic [1:0]    grant_o;

  // Source side: drives requests and observes the arbiter's decisions.
  modport master (
    output ex_wen_i, ex_waddr_i, ex_wdata_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output div_valid_i, div_waddr_i, div_wdata_i,
    input  lsu_ready_o, div_ready_o, stall_o,
    input  reg_wen_o, reg_waddr_o, reg_wdata_o, grant_o
  );

  modport slave (
    input  ex_wen_i, ex_waddr_i, ex_wdata_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  div_valid_i, div_waddr_i, div_wdata_i,
    output lsu_ready_o, div_ready_o, stall_o,
    output reg_wen_o, reg_waddr_o, reg_wdata_o, grant_o
  );
endinterface

// File: rtl/regs_wb_arbiter_rr_arb2.sv
// Two-way round-robin pick between the LSU and the DIV.
// The pointer moves past the winner whenever a pick is consumed.
module rr_arb2
  import regs_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output sec_sel_e   pick
);
  sec_sel_e ptr_r;
  sec_sel_e pick_s;

  // A lone requester wins outright; the pointer breaks ties.
  always_comb begin
    pick_s = ptr_r;
    case (req)
      2'b01:   pick_s = SEL_LSU;
      2'b10:   pick_s = SEL_DIV;
      default: pick_s = ptr_r;
    endcase
  end

  // Pointer update: the next tie goes to the source that just lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= SEL_LSU;
    end else if (adv) begin
      ptr_r <= (pick_s == SEL_LSU) ? SEL_DIV : SEL_LSU;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign pick = pick_s;
endmodule

// File: rtl/regs_wb_arbiter.sv
// Shares the register-file write port between EX, LSU and DIV writeback.
// EX has priority, and a starvation counter forces one secondary retirement.
module regs_wb_arbiter
  import regs_wb_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF
) (
  input logic           clk,
  input logic           rst_n,
  regs_wb_arbiter_if.slave wb
);
  logic          sec_pend_s;
  logic          starve_hit_s;
  logic          adv_s;
  logic          stall_s;
  logic          wen_s;
  logic [1:0]    grant_s;
  logic [1:0]    sec_gnt_s;
  logic [AW-1:0] waddr_s;
  logic [DW-1:0] wdata_s;
  logic [3:0]    starve_cnt_r;
  sec_sel_e      pick_s;

  rr_arb2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({wb.div_valid_i, wb.lsu_valid_i}),
    .adv   (adv_s),
    .pick  (pick_s)
  );

  // Grant decision and write-port mux; everything is forced low while reset is held.
  always_comb begin
    sec_pend_s   = wb.lsu_valid_i | wb.div_valid_i;
    starve_hit_s = (starve_cnt_r == 4'(STARVE_MAX)) && sec_pend_s;
    sec_gnt_s    = (pick_s == SEL_LSU) ? GNT_LSU : GNT_DIV;
    grant_s      = GNT_NONE;
    stall_s      = 1'b0;
    if (!rst_n) begin
      grant_s = GNT_NONE;
    end else if (starve_hit_s) begin
      grant_s = sec_gnt_s;
      stall_s = wb.ex_wen_i;
    end else if (wb.ex_wen_i) begin
      grant_s = GNT_EX;
    end else if (sec_pend_s) begin
      grant_s = sec_gnt_s;
    end else begin
      grant_s = GNT_NONE;
    end

    case (grant_s)
      GNT_EX:  begin waddr_s = wb.ex_waddr_i;  wdata_s = wb.ex_wdata_i;  end
      GNT_LSU: begin waddr_s = wb.lsu_waddr_i; wdata_s = wb.lsu_wdata_i; end
      GNT_DIV: begin waddr_s = wb.div_waddr_i; wdata_s = wb.div_wdata_i; end
      default: begin waddr_s = '0;             wdata_s = '0;             end
    endcase

    // x0 writes still complete their handshake, but never touch the file.
    wen_s = (grant_s != GNT_NONE) && (waddr_s != AW'(REG_ZERO));
    adv_s = (grant_s == GNT_LSU) || (grant_s == GNT_DIV);
  end

  // Starvation counter: counts EX wins against a waiting secondary, saturating at the limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_r <= 4'd0;
    end else if (adv_s || !sec_pend_s) begin
      starve_cnt_r <= 4'd0;
    end else if (grant_s == GNT_EX) begin
      if (starve_cnt_r != 4'(STARVE_MAX)) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  assign wb.grant_o     = grant_s;
  assign wb.stall_o     = stall_s;
  assign wb.reg_wen_o   = wen_s;
  assign wb.reg_waddr_o = waddr_s;
  assign wb.reg_wdata_o = wdata_s;
  assign wb.lsu_ready_o = (grant_s == GNT_LSU);
  assign wb.div_ready_o = (grant_s == GNT_DIV);
endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Directed bench for regs_wb_arbiter: expected outputs are queued when a cycle is driven
// and checked against the DUT a little after the inputs settle.
module tb_regs_wb_arbiter;
  import regs_wb_arbiter_pkg::*;

  typedef struct packed {
    logic [1:0]  gnt;
    logic        stall;
    logic        wen;
    logic        lr;
    logic        dr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } out_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  out_t exp_q[$];
  string tag_q[$];

  regs_wb_arbiter_if #(.AW(5), .DW(32)) wb ();

  regs_wb_arbiter #(.STARVE_MAX(4), .AW(5), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [4:0]  LA = 5'd3;
  localparam logic [31:0] LD = 32'hA5A5_0001;
  localparam logic [4:0]  DA = 5'd7;
  localparam logic [31:0] DD = 32'h0000_D1D1;
  localparam logic [4:0]  EA = 5'd5;
  localparam logic [31:0] ED = 32'hDEAD_BEEF;

  task automatic set_in(input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic dv, input logic [4:0] da, input logic [31:0] dd);
    wb.ex_wen_i    = ew; wb.ex_waddr_i  = ea; wb.ex_wdata_i  = ed;
    wb.lsu_valid_i = lv; wb.lsu_waddr_i = la; wb.lsu_wdata_i = ld;
    wb.div_valid_i = dv; wb.div_waddr_i = da; wb.div_wdata_i = dd;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] g, input logic st,
                            input logic wen, input logic lr, input logic dr,
                            input logic [4:0] a, input logic [31:0] d);
    out_t e;
    e.gnt = g; e.stall = st; e.wen = wen; e.lr = lr; e.dr = dr; e.waddr = a; e.wdata = d;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Let the combinational outputs settle, compare, then move to the next falling edge.
  task automatic check_cycle();
    out_t  obs;
    out_t  exp_v;
    string tag;
    #2;
    obs.gnt = wb.grant_o; obs.stall = wb.stall_o; obs.wen = wb.reg_wen_o;
    obs.lr = wb.lsu_ready_o; obs.dr = wb.div_ready_o;
    obs.waddr = wb.reg_waddr_o; obs.wdata = wb.reg_wdata_o;
    exp_v = exp_q.pop_front();
    tag   = tag_q.pop_front();
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed gnt=%0d stall=%b wen=%b lr=%b dr=%b waddr=%0d wdata=%h, expected gnt=%0d stall=%b wen=%b lr=%b dr=%b waddr=%0d wdata=%h",
             tag, obs.gnt, obs.stall, obs.wen, obs.lr, obs.dr, obs.waddr, obs.wdata,
             exp_v.gnt, exp_v.stall, exp_v.wen, exp_v.lr, exp_v.dr, exp_v.waddr, exp_v.wdata);
    end
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    set_in(1'b1, EA, ED, 1'b1, LA, LD, 1'b1, DA, DD);
    @(negedge clk);

    // Reset held with every request high: all outputs low.
    expect_out("reset0", GNT_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    check_cycle();
    expect_out("reset1", GNT_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    check_cycle();

    // Out of reset, EX idle, both secondaries valid: LSU, DIV, LSU.
    rst_n = 1'b1;
    set_in(1'b0, EA, ED, 1'b1, LA, LD, 1'b1, DA, DD);
    expect_out("rr_lsu0", GNT_LSU, 1'b0, 1'b1, 1'b1, 1'b0, LA, LD);
    check_cycle();
    expect_out("rr_div0", GNT_DIV, 1'b0, 1'b1, 1'b0, 1'b1, DA, DD);
    check_cycle();
    expect_out("rr_lsu1", GNT_LSU, 1'b0, 1'b1, 1'b1, 1'b0, LA, LD);
    check_cycle();

    // Contention with the pointer on DIV: DIV first, then LSU.
    expect_out("cont_div", GNT_DIV, 1'b0, 1'b1, 1'b0, 1'b1, DA, DD);
    check_cycle();
    expect_out("cont_lsu", GNT_LSU, 1'b0, 1'b1, 1'b1, 1'b0, LA, LD);
    check_cycle();

    // EX alone: same-cycle write.
    set_in(1'b1, EA, ED, 1'b0, LA, LD, 1'b0, DA, DD);
    expect_out("ex_only", GNT_EX, 1'b0, 1'b1, 1'b0, 1'b0, EA, ED);
    check_cycle();

    // Starvation: EX every cycle, LSU waiting. Four EX wins, then a stall cycle.
    set_in(1'b1, EA, ED, 1'b1, LA, LD, 1'b0, DA, DD);
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("starve_ex%0d", i), GNT_EX, 1'b0, 1'b1, 1'b0, 1'b0, EA, ED);
      check_cycle();
    end
    expect_out("starve_stall", GNT_LSU, 1'b1, 1'b1, 1'b1, 1'b0, LA, LD);
    check_cycle();
    set_in(1'b1, EA, ED, 1'b0, LA, LD, 1'b0, DA, DD);
    expect_out("starve_resume", GNT_EX, 1'b0, 1'b1, 1'b0, 1'b0, EA, ED);
    check_cycle();

    // Saturate the counter again, then drop EX: the secondary wins without a stall.
    set_in(1'b1, EA, ED, 1'b1, LA, LD, 1'b0, DA, DD);
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("sat_ex%0d", i), GNT_EX, 1'b0, 1'b1, 1'b0, 1'b0, EA, ED);
      check_cycle();
    end
    set_in(1'b0, EA, ED, 1'b1, LA, LD, 1'b0, DA, DD);
    expect_out("sat_ex_idle", GNT_LSU, 1'b0, 1'b1, 1'b1, 1'b0, LA, LD);
    check_cycle();

    // DIV writes x0: the handshake completes, but there is no register write.
    set_in(1'b0, EA, ED, 1'b0, LA, LD, 1'b1, 5'd0, 32'h0000_1234);
    expect_out("x0_div", GNT_DIV, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_1234);
    check_cycle();
    set_in(1'b0, EA, ED, 1'b1, LA, LD, 1'b1, DA, DD);
    expect_out("x0_ptr_lsu", GNT_LSU, 1'b0, 1'b1, 1'b1, 1'b0, LA, LD);
    check_cycle();

    // Build starve count 3 with both secondaries pending; the pointer is on DIV here.
    set_in(1'b1, EA, ED, 1'b1, LA, LD, 1'b1, DA, DD);
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("mid_ex%0d", i), GNT_EX, 1'b0, 1'b1, 1'b0, 1'b0, EA, ED);
      check_cycle();
    end
    rst_n = 1'b0;
    expect_out("mid_reset", GNT_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    check_cycle();
    rst_n = 1'b1;
    set_in(1'b0, EA, ED, 1'b1, LA, LD, 1'b1, DA, DD);
    expect_out("mid_after_lsu", GNT_LSU, 1'b0, 1'b1, 1'b1, 1'b0, LA, LD);
    check_cycle();

    // The counter must have restarted from zero: four EX wins before the next stall.
    set_in(1'b1, EA, ED, 1'b1, LA, LD, 1'b0, DA, DD);
    for (int i = 0; i < 4; i++) begin
      expect_out($sformatf("post_ex%0d", i), GNT_EX, 1'b0, 1'b1, 1'b0, 1'b0, EA, ED);
      check_cycle();
    end
    expect_out("post_stall", GNT_LSU, 1'b1, 1'b1, 1'b1, 1'b0, LA, LD);
    check_cycle();

    // Nothing pending.
    set_in(1'b0, EA, ED, 1'b0, LA, LD, 1'b0, DA, DD);
    expect_out("idle", GNT_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    check_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regs_wb_arbiter.md
Name: regs_wb_arbiter

Overview:
- Shares the register file's single write port between three writeback sources: the EX stage, the load/store unit (LSU) and the multi-cycle divider (DIV).
- EX has priority and no backpressure. LSU and DIV use a valid/ready handshake and are served round-robin in cycles EX does not write.
- A starvation counter stalls EX for one cycle so that a secondary source can retire.
- The block sits between the writeback sources and the register file write port (wen/waddr/wdata).

Parameters:
- STARVE_MAX, 4, consecutive cycles a pending secondary request may lose to EX before EX is stalled (range 1..15).
- DW, 32, write data width.
- AW, 5, register address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ex_wen_i  in  1  EX writeback request
- ex_waddr_i  in  AW  EX destination register
- ex_wdata_i  in  DW  EX write data
- lsu_valid_i  in  1  LSU writeback request
- lsu_waddr_i  in  AW  LSU destination register
- lsu_wdata_i  in  DW  LSU load data
- lsu_ready_o  out  1  LSU request accepted this cycle
- div_valid_i  in  1  DIV writeback request
- div_waddr_i  in  AW  DIV destination register
- div_wdata_i  in  DW  DIV result
- div_ready_o  out  1  DIV request accepted this cycle
- stall_o  out  1  EX must hold its request; EX is not written this cycle
- reg_wen_o  out  1  register file write enable
- reg_waddr_o  out  AW  register file write address
- reg_wdata_o  out  DW  register file write data
- grant_o  out  2  current grant: 0 none, 1 EX, 2 LSU, 3 DIV

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - rr_ptr := LSU; starve_cnt := 0.
  - While rst_n=0, all outputs are forced to 0 (ready, stall, wen, waddr, wdata, grant), independent of state.
- Outputs are combinational from the current state and inputs, so accepted data reaches reg_w*_o in the same cycle (zero latency). This preserves the register file's same-cycle write-to-read bypass.
- Only state elements: rr_ptr (1 bit) and starve_cnt (4 bits).
- Secondary pending (sec_pend) = lsu_valid_i | div_valid_i.
- sec_pick:
  - The valid secondary if exactly one is valid.
  - rr_ptr if both are valid.
- Grant rules, evaluated each cycle:
  1. starve_cnt == STARVE_MAX and sec_pend: grant sec_pick; stall_o = ex_wen_i (stall only if EX actually wants the port).
  2. else if ex_wen_i: grant EX; stall_o = 0.
  3. else if sec_pend: grant sec_pick.
  4. else: grant none.
- The granted secondary's ready is 1; the other ready is 0.
- On a secondary grant, rr_ptr := the other secondary at the clock edge.
- starve_cnt update:
  - := 0 if a secondary is granted or !sec_pend.
  - else +1 if EX is granted, saturating at STARVE_MAX.
  - else holds.
- x0 writes:
  - A granted request with waddr == 0 still completes its handshake (ready=1, rr_ptr advances).
  - reg_wen_o is 0 in that case; reg_waddr_o/reg_wdata_o still reflect the granted source.
- Secondaries must hold valid/waddr/wdata stable until ready. EX must hold ex_* stable while stall_o=1.
- Both secondaries valid with EX idle: one grant per cycle, alternating LSU, DIV, LSU, and so on.
- STARVE_MAX reached but EX idle: rule 1 still grants the secondary, with stall_o=0.
- A mid-operation reset drops the grant immediately. Pending requests are re-arbitrated from rr_ptr=LSU after reset.

Decomposition:
- Shared package:
  - grant encoding constants GNT_NONE/GNT_EX/GNT_LSU/GNT_DIV.
  - AW/DW defaults.
  - REG_ZERO = 5'd0.
- One natural sub-module, `rr_arb2`: 2-way round-robin pick with pointer update. It takes reqs and an advance enable and outputs the pick.
- The starvation counter and the mux stay in the top module.

Test Plan:
- Reset: rst_n=0 with all requests high -> every output 0. Release reset, LSU and DIV both valid, EX idle -> grants LSU, then DIV, then LSU on consecutive cycles.
- EX only: ex_wen_i=1, waddr=5, wdata=0xDEADBEEF -> same cycle reg_wen_o=1, waddr 5, wdata 0xDEADBEEF, grant_o=1, stall_o=0.
- Starvation: EX writes every cycle, lsu_valid_i held from cycle 0 (STARVE_MAX=4) -> EX granted cycles 0-3. Cycle 4: stall_o=1, lsu_ready_o=1, grant_o=2. Cycle 5: EX granted again.
- x0 drop: DIV valid, waddr=0, data 0x1234 -> div_ready_o=1, reg_wen_o=0; rr_ptr advances to LSU.
- Contention: EX idle, LSU and DIV valid, rr_ptr=DIV -> DIV granted first, LSU next cycle; starve_cnt stays 0 throughout.
- Mid-operation reset: both secondaries pending with starve_cnt=3, assert rst_n=0 for one cycle -> outputs 0 that cycle. Next cycle LSU is granted (rr_ptr=LSU) and starve_cnt=0.
